uart_rx: RTL and testbench
==========================

# uart_rx

UART receive stage that sits directly downstream of the baud-rate tick generator. It consumes the generator's single-cycle oversampling tick (16 ticks per bit) and the asynchronous serial line, and recovers each frame: start bit, DBIT data bits LSB first, optional parity, and stop bit. It delivers the received byte with a one-cycle done strobe plus frame and parity error flags to the receive FIFO or host logic.

## Interface
- DBIT, default 8: data bits per frame. Legal range 5..8.
- SB_TICK, default 16: stop-bit length in ticks. 16 = 1 stop bit, 24 = 1.5, 32 = 2.
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- s_tick  input  1  oversampling tick from the baud-rate generator; one clk wide, 16 per bit period.
- parity_en  input  1  1 = a parity bit follows the data bits.
- parity_odd  input  1  1 = odd parity, 0 = even parity. Ignored when parity_en = 0.
- dout  output  DBIT  last received data word.
- rx_done_tick  output  1  one-cycle strobe; dout, frame_err and parity_err are valid in this cycle.
- frame_err  output  1  stop bit sampled low in the last frame.
- parity_err  output  1  parity mismatch in the last frame. Always 0 when parity was disabled.

## Operation
- rx passes through a 2-flop synchronizer to give rx_s. A third flop, rx_q, holds the previous rx_s for edge detection.
- Counters:
  - s: 5-bit tick counter. Advances only in cycles where s_tick = 1.
  - n: 3-bit data-bit index.
  - b: DBIT-wide shift register.
  - p: running XOR of the received data bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - A falling edge (rx_q = 1, rx_s = 0) moves to START and clears s.
  - parity_en and parity_odd are latched on this edge. Changes during the frame are ignored.
  - A line held low does not retrigger the FSM.
- START: on a tick with s = 7 (mid start bit):
  - If rx_s = 0: clear s and n, go to DATA.
  - If rx_s = 1: false start. Return to IDLE with no strobe.
- DATA: on a tick with s = 15:
  - Shift rx_s into the MSB of b (right shift, LSB first). Fold rx_s into p.
  - Clear s.
  - If n = DBIT-1, go to PARITY when parity is enabled, otherwise STOP. Otherwise increment n.
- PARITY: on a tick with s = 15:
  - Record the mismatch: (p XOR rx_s) != latched parity_odd.
  - Clear s and go to STOP.
- STOP:
  - On a tick with s = 7 (mid stop bit), record the stop level.
  - On a tick with s = SB_TICK-1, go to IDLE and pulse rx_done_tick.
  - In that same cycle, load dout = b, frame_err = (recorded stop level = 0), and parity_err = recorded mismatch (0 if parity was disabled).
- dout, frame_err and parity_err are registered. They change only in a rx_done_tick cycle and hold between frames.
- Frames with errors are still strobed and delivered.
- Clock cycles without s_tick leave the FSM and counters unchanged.

## Timing
- Reset values: state IDLE; s, n, b, p = 0; synchronizer flops = 1; dout = 0; rx_done_tick = 0; frame_err = 0; parity_err = 0.
- Reset in any state aborts the frame in the next cycle. No strobe is produced, and the outputs return to their reset values.
- Line-to-detection latency is 2 clk (synchronizer) plus 1 clk (edge).
- A complete frame takes 8 + 16·DBIT + 16·parity_en + SB_TICK ticks after the falling edge is detected. Tick alignment adds up to 1 tick of jitter.
- rx_done_tick is high for exactly one clk per frame. It occurs on the clk edge of the final stop tick.
- A new falling edge is accepted from the first IDLE cycle after rx_done_tick. Back-to-back frames are supported with no idle bits.
- All arithmetic is unsigned. s wraps only by explicit clear, never by overflow.

## Test plan
- Use s_tick every 4 clk throughout (tick period of 4 clk).
- Frame 0xA5, 8N1, rx ideal → exactly one rx_done_tick; dout = 0xA5; frame_err = 0; parity_err = 0. Strobe occurs 2+1+(8+128+16)·4 ±4 clk after the rx falling edge.
- Frames 0x3C then 0xC3, even parity, correct parity bits, back-to-back with no idle bit → two strobes; dout = 0x3C then 0xC3; no errors. Repeat 0x3C with the parity bit inverted → parity_err = 1; dout = 0x3C.
- Frame 0x55 with stop bit driven 0, then the line held low for 40 bit times → one strobe with frame_err = 1 and no further strobes. Releasing the line high and sending 0x0F → dout = 0x0F, frame_err = 0.
- Low glitch of 5 ticks on an idle line → no strobe; FSM back in IDLE. The next valid frame 0x81 is received correctly.
- Reset pulsed mid-DATA of frame 0xFF → no strobe for that frame; all outputs 0. The following frame 0x12 is received correctly.
- Set DBIT = 7 and SB_TICK = 32, then send 0x5A with odd parity → dout = 0x5A; rx_done_tick lands 16 ticks later than for SB_TICK = 16.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: recovers start, DBIT data bits (LSB first), optional parity and stop
// from a 16x oversampled line, delivering registered data/error flags with a done strobe.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    input  logic            parity_en,
    input  logic            parity_odd,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [4:0] S_MID  = 5'd7;
    localparam logic [4:0] S_BIT  = 5'd15;
    localparam logic [4:0] S_STOP = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST = 3'(DBIT - 1);

    state_t          state_reg, state_next;
    logic            rx_meta_reg, rx_s_reg, rx_q_reg;
    logic [4:0]      s_reg, s_next;
    logic [2:0]      n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic            p_reg, p_next;
    logic            par_en_reg, par_en_next;
    logic            par_odd_reg, par_odd_next;
    logic            stop_lvl_reg, stop_lvl_next;
    logic            par_mis_reg, par_mis_next;
    logic [DBIT-1:0] dout_reg, dout_next;
    logic            done_reg, done_next;
    logic            frame_err_reg, frame_err_next;
    logic            parity_err_reg, parity_err_next;
    logic            fall_edge;

    assign fall_edge = rx_q_reg & ~rx_s_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg    <= 1'b1;
            rx_s_reg       <= 1'b1;
            rx_q_reg       <= 1'b1;
            state_reg      <= IDLE;
            s_reg          <= '0;
            n_reg          <= '0;
            b_reg          <= '0;
            p_reg          <= 1'b0;
            par_en_reg     <= 1'b0;
            par_odd_reg    <= 1'b0;
            stop_lvl_reg   <= 1'b1;
            par_mis_reg    <= 1'b0;
            dout_reg       <= '0;
            done_reg       <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
        end else begin
            rx_meta_reg    <= rx;
            rx_s_reg       <= rx_meta_reg;
            rx_q_reg       <= rx_s_reg;
            state_reg      <= state_next;
            s_reg          <= s_next;
            n_reg          <= n_next;
            b_reg          <= b_next;
            p_reg          <= p_next;
            par_en_reg     <= par_en_next;
            par_odd_reg    <= par_odd_next;
            stop_lvl_reg   <= stop_lvl_next;
            par_mis_reg    <= par_mis_next;
            dout_reg       <= dout_next;
            done_reg       <= done_next;
            frame_err_reg  <= frame_err_next;
            parity_err_reg <= parity_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        s_next          = s_reg;
        n_next          = n_reg;
        b_next          = b_reg;
        p_next          = p_reg;
        par_en_next     = par_en_reg;
        par_odd_next    = par_odd_reg;
        stop_lvl_next   = stop_lvl_reg;
        par_mis_next    = par_mis_reg;
        dout_next       = dout_reg;
        done_next       = 1'b0;
        frame_err_next  = frame_err_reg;
        parity_err_next = parity_err_reg;

        case (state_reg)
            IDLE: begin
                // Parity mode is frozen for the whole frame at the start edge.
                if (fall_edge) begin
                    state_next   = START;
                    s_next       = '0;
                    p_next       = 1'b0;
                    par_mis_next = 1'b0;
                    par_en_next  = parity_en;
                    par_odd_next = parity_odd;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == S_MID) begin
                        if (!rx_s_reg) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_BIT) begin
                        b_next = {rx_s_reg, b_reg[DBIT-1:1]};
                        p_next = p_reg ^ rx_s_reg;
                        s_next = '0;
                        if (n_reg == N_LAST)
                            state_next = par_en_reg ? PARITY : STOP;
                        else
                            n_next = n_reg + 3'd1;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == S_BIT) begin
                        par_mis_next = ((p_reg ^ rx_s_reg) != par_odd_reg);
                        s_next       = '0;
                        state_next   = STOP;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == S_MID)
                        stop_lvl_next = rx_s_reg;
                    if (s_reg == S_STOP) begin
                        state_next      = IDLE;
                        done_next       = 1'b1;
                        dout_next       = b_reg;
                        frame_err_next  = ~stop_lvl_reg;
                        parity_err_next = par_en_reg & par_mis_reg;
                    end else begin
                        s_next = s_reg + 5'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dout         = dout_reg;
    assign rx_done_tick = done_reg;
    assign frame_err    = frame_err_reg;
    assign parity_err   = parity_err_reg;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a table of frames plus hand-written corner sequences; expected
// results are queued when a frame is driven and compared when each strobe appears.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int BIT_CLK = 64;

    typedef struct {
        logic [7:0] data;
        logic       fe;
        logic       pe;
        int         nominal;
        int         start;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_odd;
        logic       par_flip;
        logic       stop_val;
        logic [7:0] exp_dout;
        logic       exp_fe;
        logic       exp_pe;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx2 = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       s_tick;
    logic [1:0] tick_ph = 2'd0;
    int         cycle_cnt = 0;

    logic [7:0] dout;
    logic       rx_done_tick, frame_err, parity_err;
    logic [6:0] dout2;
    logic       rx_done_tick2, frame_err2, parity_err2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    vec_t vecs[6];
    int   n_checks = 0;
    int   n_errors = 0;
    int   strobes0 = 0;
    int   strobes1 = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tick_ph   <= tick_ph + 2'd1;
        cycle_cnt <= cycle_cnt + 1;
    end
    assign s_tick = (tick_ph == 2'd3);

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut0 (
        .clk(clk), .reset(reset), .rx(rx), .s_tick(s_tick),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .dout(dout), .rx_done_tick(rx_done_tick),
        .frame_err(frame_err), .parity_err(parity_err)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32)) dut1 (
        .clk(clk), .reset(reset), .rx(rx2), .s_tick(s_tick),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .dout(dout2), .rx_done_tick(rx_done_tick2),
        .frame_err(frame_err2), .parity_err(parity_err2)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_win(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Start edges land one cycle after a tick edge, so every sample point sits
    // inside its bit after synchronizer delay.
    task automatic align();
        while (tick_ph != 2'd1) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input bit sel, input logic v);
        if (sel) rx2 = v;
        else     rx  = v;
        wait_clk(BIT_CLK);
    endtask

    task automatic send_frame(input bit sel, input int nbits, input int sb_ticks,
                              input logic [7:0] data, input logic pen, input logic podd,
                              input logic pflip, input logic stop_val,
                              input logic [7:0] exp_dout, input logic exp_fe,
                              input logic exp_pe);
        exp_t       e;
        logic [7:0] m;
        align();
        parity_en  = pen;
        parity_odd = podd;
        m          = 8'((1 << nbits) - 1);
        e.data     = exp_dout;
        e.fe       = exp_fe;
        e.pe       = exp_pe;
        e.nominal  = 3 + 4 * (8 + 16 * nbits + 16 * int'(pen) + sb_ticks);
        e.start    = cycle_cnt;
        if (sel) q1.push_back(e);
        else     q0.push_back(e);
        drive(sel, 1'b0);
        for (int i = 0; i < nbits; i++) drive(sel, data[i]);
        if (pen) drive(sel, (^(data & m)) ^ podd ^ pflip);
        drive(sel, stop_val);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[2] = '{8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1};
        vecs[4] = '{8'h96, 1'b1, 1'b1, 1'b0, 1'b1, 8'h96, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};

        fork
            forever begin
                @(negedge clk);
                if (rx_done_tick) begin
                    strobes0++;
                    if (q0.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rx0_strobe: got unexpected strobe dout=0x%0h, expected none", dout);
                    end else begin
                        e0 = q0.pop_front();
                        $display("rx0 frame: dout=0x%0h frame_err=%0b parity_err=%0b latency=%0d",
                                 dout, frame_err, parity_err, cycle_cnt - e0.start);
                        check("rx0_dout", dout, e0.data);
                        check("rx0_frame_err", frame_err, e0.fe);
                        check("rx0_parity_err", parity_err, e0.pe);
                        check_win("rx0_latency", cycle_cnt - e0.start, e0.nominal - 4, e0.nominal + 4);
                    end
                end
                if (rx_done_tick2) begin
                    strobes1++;
                    if (q1.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rx1_strobe: got unexpected strobe dout=0x%0h, expected none", dout2);
                    end else begin
                        e1 = q1.pop_front();
                        $display("rx1 frame: dout=0x%0h frame_err=%0b parity_err=%0b latency=%0d",
                                 dout2, frame_err2, parity_err2, cycle_cnt - e1.start);
                        check("rx1_dout", dout2, e1.data[6:0]);
                        check("rx1_frame_err", frame_err2, e1.fe);
                        check("rx1_parity_err", parity_err2, e1.pe);
                        check_win("rx1_latency", cycle_cnt - e1.start, e1.nominal - 4, e1.nominal + 4);
                    end
                end
            end
        join_none

        wait_clk(4);
        check("reset_dout", dout, 0);
        check("reset_done", rx_done_tick, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_parity_err", parity_err, 0);
        check("reset_dout2", dout2, 0);
        reset = 1'b0;
        wait_clk(10);

        // Table frames are sent back to back with no idle bits between them.
        for (int i = 0; i < 6; i++)
            send_frame(1'b0, 8, 16, vecs[i].data, vecs[i].par_en, vecs[i].par_odd,
                       vecs[i].par_flip, vecs[i].stop_val, vecs[i].exp_dout,
                       vecs[i].exp_fe, vecs[i].exp_pe);
        wait_clk(200);
        check("table_strobe_count", strobes0, 6);

        // Stop bit low, then the line stays low: one strobe only, outputs hold.
        send_frame(1'b0, 8, 16, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0);
        wait_clk(40 * BIT_CLK);
        check("held_low_strobe_count", strobes0, 7);
        check("held_low_dout_hold", dout, 8'h55);
        check("held_low_frame_err_hold", frame_err, 1);
        rx = 1'b1;
        wait_clk(BIT_CLK);
        send_frame(1'b0, 8, 16, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0);
        wait_clk(BIT_CLK);
        check("recover_strobe_count", strobes0, 8);

        // Five-tick low glitch is rejected at mid start bit.
        align();
        rx = 1'b0;
        wait_clk(20);
        rx = 1'b1;
        wait_clk(4 * BIT_CLK);
        check("glitch_strobe_count", strobes0, 8);
        check("glitch_dout_hold", dout, 8'h0F);
        send_frame(1'b0, 8, 16, 8'h81, 1'b1, 1'b1, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0);
        wait_clk(BIT_CLK);
        check("after_glitch_strobe_count", strobes0, 9);

        // Reset in the middle of the data bits of 0xFF.
        align();
        rx = 1'b0;
        wait_clk(BIT_CLK);
        rx = 1'b1;
        wait_clk(3 * BIT_CLK);
        reset = 1'b1;
        wait_clk(1);
        reset = 1'b0;
        check("midreset_dout", dout, 0);
        check("midreset_done", rx_done_tick, 0);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_parity_err", parity_err, 0);
        wait_clk(8 * BIT_CLK);
        check("midreset_strobe_count", strobes0, 9);
        send_frame(1'b0, 8, 16, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 8'h12, 1'b0, 1'b0);
        wait_clk(BIT_CLK);
        check("after_reset_strobe_count", strobes0, 10);

        // Seven data bits, odd parity, two stop bits on the second instance.
        send_frame(1'b1, 7, 32, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
        wait_clk(2 * BIT_CLK);
        check("dbit7_strobe_count", strobes1, 1);

        wait_clk(100);
        check("rx0_pending", q0.size(), 0);
        check("rx1_pending", q1.size(), 0);
        check("rx0_total_strobes", strobes0, 10);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
